// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator for byte/half/word loads and stores, with
// read-modify-write for sub-word stores. Optional accept-time trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int WL       = 32,
  parameter int DM_WORDS = 1025
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [WL-1:0] req_addr,
  input  logic [WL-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [WL-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [WL-1:0] dm_addr,
  output logic [WL-1:0] dm_wdata,
  output logic          dm_we,
  input  logic [WL-1:0] dm_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RSP  = 2'b11
  } state_t;

  state_t        state_r;
  logic [1:0]    off_r;
  logic [1:0]    size_r;
  logic          uns_r;
  logic          we_r;
  logic [WL-1:0] wdata_r;
  logic          trap_s;

  // Pick the addressed lane of a read word and sign/zero-extend it.
  function automatic logic [WL-1:0] extract_load(input logic [WL-1:0] word,
                                                 input logic [1:0]    size,
                                                 input logic [1:0]    off,
                                                 input logic          uns);
    logic [7:0]    b;
    logic [15:0]   h;
    logic [WL-1:0] res;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = {{(WL-8){b[7] & ~uns}}, b};
      2'b01:   res = {{(WL-16){h[15] & ~uns}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay the store data onto the old word at the addressed lane.
  function automatic logic [WL-1:0] merge_store(input logic [WL-1:0] old,
                                                input logic [WL-1:0] wd,
                                                input logic [1:0]    size,
                                                input logic [1:0]    off);
    logic [WL-1:0] res;
    res = old;
    case (size)
      2'b00:   res[{off, 3'b000} +: 8] = wd[7:0];
      2'b01:   res[{off[1], 4'b0000} +: 16] = wd[15:0];
      default: res = wd;
    endcase
    return res;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  localparam logic [WL-1:0] MAX_IDX = WL'(DM_WORDS - 1);
  logic misalign_s;
  logic range_s;

  // Alignment check of the incoming request; size 11 behaves as a word.
  always_comb begin
    misalign_s = 1'b0;
    case (req_size)
      2'b00:   misalign_s = 1'b0;
      2'b01:   misalign_s = req_addr[0];
      default: misalign_s = (req_addr[1:0] != 2'b00);
    endcase
  end

  assign range_s = ({2'b00, req_addr[WL-1:2]} > MAX_IDX);
  assign trap_s  = misalign_s | range_s;
`else
  assign trap_s  = 1'b0;
`endif

  assign req_ready = (state_r == IDLE);

  // Request sequencing; every output except req_ready is a register here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      off_r     <= 2'b00;
      size_r    <= 2'b00;
      uns_r     <= 1'b0;
      we_r      <= 1'b0;
      wdata_r   <= {WL{1'b0}};
      dm_addr   <= {WL{1'b0}};
      dm_wdata  <= {WL{1'b0}};
      dm_we     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= {WL{1'b0}};
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          dm_we     <= 1'b0;
          rsp_valid <= 1'b0;
          if (req_valid) begin
            off_r   <= req_addr[1:0];
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            we_r    <= req_we;
            wdata_r <= req_wdata;
            if (trap_s) begin
              // Trapped requests never reach memory.
              state_r   <= RSP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= {WL{1'b0}};
            end else if (req_we && req_size[1]) begin
              dm_addr  <= {2'b00, req_addr[WL-1:2]};
              state_r  <= WR;
              dm_we    <= 1'b1;
              dm_wdata <= req_wdata;
            end else begin
              dm_addr <= {2'b00, req_addr[WL-1:2]};
              state_r <= RD;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        RD: begin
          dm_we <= 1'b0;
          if (we_r) begin
            state_r  <= WR;
            dm_we    <= 1'b1;
            dm_wdata <= merge_store(dm_rdata, wdata_r, size_r, off_r);
          end else begin
            state_r   <= RSP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= extract_load(dm_rdata, size_r, off_r, uns_r);
          end
        end
        WR: begin
          state_r   <= RSP;
          dm_we     <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= {WL{1'b0}};
        end
        RSP: begin
          state_r   <= IDLE;
          dm_we     <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          dm_we     <= 1'b0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural data memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_rdata;

  logic [31:0] mem [0:1024];

  int tests = 0;
  int fails = 0;

  int          we_cnt;
  int          we_cyc;
  int          rsp_cyc;
  logic [31:0] we_data;
  logic [31:0] c1_addr;
  logic [31:0] rsp_data;
  logic        rsp_e;

  load_store_unit #(.WL(32), .DM_WORDS(1025)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata = (dm_addr < 32'd1025) ? mem[dm_addr[10:0]] : 32'h0;

  // Issue one request, then watch up to 8 cycles for dm_we and the response.
  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    we_cnt = 0; we_cyc = -1; rsp_cyc = -1;
    we_data = 32'h0; rsp_data = 32'h0; rsp_e = 1'b0;
    c1_addr = dm_addr;
    for (int c = 1; c <= 8; c++) begin
      if (dm_we) begin
        we_cnt++;
        if (we_cyc < 0) begin we_cyc = c; we_data = dm_wdata; end
        if (dm_addr < 32'd1025) mem[dm_addr[10:0]] = dm_wdata;
      end
      if (rsp_valid) begin
        rsp_cyc = c; rsp_data = rsp_rdata; rsp_e = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    tests++; if (dm_we !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got we=%b valid=%b err=%b expected 0 0 0", dm_we, rsp_valid, rsp_err); end
    tests++; if (dm_addr !== 32'h0 || dm_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      fails++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected zeros", dm_addr, dm_wdata, rsp_rdata); end
  endtask

  task automatic test_load_byte();
    mem[3] = 32'h8899AABB;
    run_op(1'b0, 2'b00, 1'b0, 32'h0000000E, 32'h0);
    tests++; if (c1_addr !== 32'd3) begin fails++; $display("FAIL lb_addr: got %h expected 3", c1_addr); end
    tests++; if (rsp_cyc !== 2) begin fails++; $display("FAIL lb_latency: got %0d expected 2", rsp_cyc); end
    tests++; if (rsp_data !== 32'hFFFFFF99) begin fails++; $display("FAIL lb_signed: got %h expected FFFFFF99", rsp_data); end
    run_op(1'b0, 2'b00, 1'b1, 32'h0000000E, 32'h0);
    tests++; if (rsp_data !== 32'h00000099) begin fails++; $display("FAIL lbu: got %h expected 00000099", rsp_data); end
  endtask

  task automatic test_store_byte();
    run_op(1'b1, 2'b00, 1'b0, 32'h0000000D, 32'h0000005C);
    tests++; if (we_cnt !== 1 || we_cyc !== 2) begin fails++; $display("FAIL sb_we: got count=%0d cycle=%0d expected 1 2", we_cnt, we_cyc); end
    tests++; if (we_data !== 32'h88995CBB) begin fails++; $display("FAIL sb_wdata: got %h expected 88995CBB", we_data); end
    tests++; if (rsp_cyc !== 3 || rsp_data !== 32'h0) begin fails++; $display("FAIL sb_rsp: got cycle=%0d rdata=%h expected 3 0", rsp_cyc, rsp_data); end
    run_op(1'b0, 2'b10, 1'b0, 32'h0000000C, 32'h0);
    tests++; if (rsp_data !== 32'h88995CBB) begin fails++; $display("FAIL sb_readback: got %h expected 88995CBB", rsp_data); end
  endtask

  task automatic test_store_word();
    run_op(1'b1, 2'b10, 1'b0, 32'h00000010, 32'hDEADBEEF);
    tests++; if (c1_addr !== 32'd4) begin fails++; $display("FAIL sw_addr: got %h expected 4", c1_addr); end
    tests++; if (we_cnt !== 1 || we_cyc !== 1) begin fails++; $display("FAIL sw_we: got count=%0d cycle=%0d expected 1 1", we_cnt, we_cyc); end
    tests++; if (rsp_cyc !== 2 || rsp_e !== 1'b0) begin fails++; $display("FAIL sw_rsp: got cycle=%0d err=%b expected 2 0", rsp_cyc, rsp_e); end
    tests++; if (mem[4] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_mem: got %h expected DEADBEEF", mem[4]); end
    run_op(1'b0, 2'b01, 1'b0, 32'h00000012, 32'h0);
    tests++; if (rsp_data !== 32'hFFFFDEAD) begin fails++; $display("FAIL lh_signed: got %h expected FFFFDEAD", rsp_data); end
  endtask

  task automatic test_half();
    mem[5] = 32'hCAFEF00D;
    run_op(1'b1, 2'b01, 1'b0, 32'h00000016, 32'hFFFF1234);
    tests++; if (we_cyc !== 2 || we_data !== 32'h1234F00D) begin fails++; $display("FAIL sh_write: got cycle=%0d data=%h expected 2 1234F00D", we_cyc, we_data); end
    run_op(1'b0, 2'b01, 1'b1, 32'h00000015, 32'h0);
    tests++; if (rsp_data !== 32'h0000F00D) begin fails++; $display("FAIL lhu_odd: got %h expected 0000F00D", rsp_data); end
    run_op(1'b0, 2'b00, 1'b0, 32'h00000017, 32'h0);
    tests++; if (rsp_data !== 32'h00000012) begin fails++; $display("FAIL lb_lane3: got %h expected 00000012", rsp_data); end
    run_op(1'b0, 2'b11, 1'b0, 32'h00000014, 32'h0);
    tests++; if (rsp_data !== 32'h1234F00D) begin fails++; $display("FAIL size11_load: got %h expected 1234F00D", rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic [9:1]  er;
    logic [9:1]  ev;
    logic [31:0] ed [1:9];
    mem[6] = 32'h11111111;
    mem[7] = 32'h22222222;
    er = 9'b100100100;
    ev = 9'b010010010;
    for (int i = 1; i <= 9; i++) ed[i] = 32'h0;
    ed[2] = 32'h11111111; ed[5] = 32'h22222222; ed[8] = 32'h88995CBB;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h18;
    @(posedge clk); #1;
    req_addr = 32'h1C;
    for (int c = 1; c <= 9; c++) begin
      tests++; if (req_ready !== er[c]) begin fails++; $display("FAIL b2b_ready_c%0d: got %b expected %b", c, req_ready, er[c]); end
      tests++; if (rsp_valid !== ev[c]) begin fails++; $display("FAIL b2b_valid_c%0d: got %b expected %b", c, rsp_valid, ev[c]); end
      if (ev[c]) begin
        tests++; if (rsp_rdata !== ed[c]) begin fails++; $display("FAIL b2b_data_c%0d: got %h expected %h", c, rsp_rdata, ed[c]); end
      end
      if (c == 4) req_addr = 32'h0C;
      if (c == 7) req_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    mem[8] = 32'hA5A5A5A5;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++; if (dm_addr !== 32'd8 || req_ready !== 1'b0) begin fails++; $display("FAIL rmid_rd: got addr=%h ready=%b expected 8 0", dm_addr, req_ready); end
    #1 rst = 1'b1;
    #1;
    tests++; if (dm_we !== 1'b0 || rsp_valid !== 1'b0 || dm_addr !== 32'h0 || dm_wdata !== 32'h0) begin
      fails++; $display("FAIL rmid_async: got we=%b valid=%b addr=%h wdata=%h expected 0 0 0 0", dm_we, rsp_valid, dm_addr, dm_wdata); end
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (dm_we) begin seen++; mem[dm_addr[10:0]] = dm_wdata; end
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL rmid_we: got %0d pulses expected 0", seen); end
    tests++; if (mem[8] !== 32'hA5A5A5A5) begin fails++; $display("FAIL rmid_mem: got %h expected A5A5A5A5", mem[8]); end
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      fails++; $display("FAIL rmid_after: got ready=%b valid=%b rdata=%h err=%b expected 1 0 0 0", req_ready, rsp_valid, rsp_rdata, rsp_err); end
  endtask

  task automatic test_misalign();
    mem[1] = 32'h0;
    run_op(1'b1, 2'b10, 1'b0, 32'h00000006, 32'hCAFE0001);
`ifdef LSU_MISALIGN_TRAP_EN
    tests++; if (rsp_cyc !== 1 || rsp_e !== 1'b1) begin fails++; $display("FAIL trap_store: got cycle=%0d err=%b expected 1 1", rsp_cyc, rsp_e); end
    tests++; if (we_cnt !== 0 || mem[1] !== 32'h0) begin fails++; $display("FAIL trap_nowrite: got we=%0d mem=%h expected 0 0", we_cnt, mem[1]); end
    run_op(1'b0, 2'b10, 1'b0, 32'h00001004, 32'h0);
    tests++; if (rsp_cyc !== 1 || rsp_e !== 1'b1 || rsp_data !== 32'h0) begin
      fails++; $display("FAIL trap_range: got cycle=%0d err=%b rdata=%h expected 1 1 0", rsp_cyc, rsp_e, rsp_data); end
`else
    tests++; if (c1_addr !== 32'd1 || we_cyc !== 1) begin fails++; $display("FAIL misalign_we: got addr=%h cycle=%0d expected 1 1", c1_addr, we_cyc); end
    tests++; if (mem[1] !== 32'hCAFE0001 || rsp_e !== 1'b0) begin fails++; $display("FAIL misalign_write: got mem=%h err=%b expected CAFE0001 0", mem[1], rsp_e); end
`endif
  endtask

  initial begin
    for (int i = 0; i <= 1024; i++) mem[i] = 32'h0;
    test_reset();
    test_load_byte();
    test_store_byte();
    test_store_word();
    test_half();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
